// File: rtl/ldl_pipe_pkg.sv
// Shared definitions for the ldl elastic register pipeline.
//
// Contents:
//   ldl_cnt_w(level) - width of the occupancy counter for a pipeline of `level`
//                      stages: enough bits to hold 0..level, and never less than 1.
package ldl_pipe_pkg;

  function automatic int ldl_cnt_w(input int level);
    int w;
    w = $clog2(level + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ldl_pipe_stage.sv
// One stage of the elastic pipeline: a valid bit plus a WIDTH-bit data register.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset (clears valid; clears data if RST_DATA)
//   load   - stage takes the upstream beat (or bubble) this cycle
//   flush  - drop the held beat; wins over load
//   in_v   - upstream valid
//   in_d   - upstream data
//   out_v  - registered valid of this stage
//   out_d  - registered data of this stage
module ldl_pipe_stage #(
  parameter int WIDTH    = 1,
  parameter bit RST_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             flush,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_v,
  output logic [WIDTH-1:0] out_d
);

  logic             v_d, v_q;
  logic [WIDTH-1:0] d_d, d_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (load) begin
      v_d = in_v;
      // Data only moves with a real beat; a bubble leaves the old value in place.
      if (in_v) d_d = in_d;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // all stages sample their neighbours' old values on the same edge.
  always_ff @(posedge clk) begin
    if (rst) v_q <= 1'b0;
    else     v_q <= v_d;
  end

  // NOTE: the data register is reset only when RST_DATA asks for it; otherwise
  // it stays reset-free, since a cleared valid bit already masks its contents.
  always_ff @(posedge clk) begin
    if (RST_DATA && rst) d_q <= '0;
    else                 d_q <= d_d;
  end

  assign out_v = v_q;
  assign out_d = d_q;

endmodule

// File: rtl/ldl_dff_pipe_v2.sv
// Elastic LEVEL-stage register pipeline with valid/ready handshake, bubble
// collapse, synchronous flush, global enable and an occupancy count.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   en                  - global enable; 0 freezes all state (flush still acts)
//   flush               - drop all in-flight beats; input beat is refused
//   in_valid/in_ready   - upstream handshake, in_data carries the beat
//   out_valid/out_ready - downstream handshake, out_data carries the beat
//   count               - number of valid stages (registered)
//
// LEVEL = 0 degenerates to a combinational pass-through with count = 0.
module ldl_dff_pipe_v2
  import ldl_pipe_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int LEVEL    = 1,
  parameter bit RST_DATA = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [ldl_cnt_w(LEVEL)-1:0] count
);

  if (LEVEL == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst};

    assign in_ready  = out_ready & en & ~flush;
    assign out_valid = in_valid & en & ~flush;
    assign out_data  = in_data;
    assign count     = '0;
  end else begin : g_pipe
    localparam int CNT_W = ldl_cnt_w(LEVEL);

    // Index 0 is the upstream port; 1..LEVEL are the registered stages.
    logic [LEVEL:0]   v;
    logic [LEVEL:0]   rdy;
    logic [WIDTH-1:0] d [0:LEVEL];

    assign v[0]       = in_valid;
    assign d[0]       = in_data;
    assign rdy[LEVEL] = out_ready & en;

    for (genvar k = 1; k <= LEVEL; k++) begin : g_stage
      // A stage can take a new beat when it is empty or its beat moves on,
      // which is exactly the ready it offers upstream. An empty stage loads
      // even under downstream stall, so bubbles close up.
      assign rdy[k-1] = en & (~v[k] | rdy[k]);

      ldl_pipe_stage #(
        .WIDTH   (WIDTH),
        .RST_DATA(RST_DATA)
      ) u_stage (
        .clk  (clk),
        .rst  (rst),
        .load (rdy[k-1]),
        .flush(flush),
        .in_v (v[k-1]),
        .in_d (d[k-1]),
        .out_v(v[k]),
        .out_d(d[k])
      );
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[LEVEL] & en;
    assign out_data  = d[LEVEL];

    // Beats enter only at stage 1 and leave only at stage LEVEL, so tracking
    // push/pop keeps the counter equal to the popcount of the valid bits.
    logic             push, pop;
    logic [CNT_W-1:0] count_d, count_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
      count_d = count_q;
      if (flush)   count_d = '0;
      else if (en) count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
    end

    assign count = count_q;
  end

endmodule

// File: tb/tb_ldl_dff_pipe_v2.sv
// Directed bench for ldl_dff_pipe_v2: a LEVEL=3 instance driven through
// streaming, backpressure, bubble collapse, flush, reset and enable cases,
// checked against a scoreboard of accepted beats; plus a LEVEL=0 instance
// checked as a combinational pass-through.
module tb_ldl_dff_pipe_v2;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } beat_t;

  logic       clk;
  // LEVEL = 3 instance
  logic       rst, en, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [1:0] count;
  // LEVEL = 0 instance
  logic       rst0, en0, flush0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [7:0] in_data0, out_data0;
  logic [0:0] count0;

  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    sb_on    = 1'b0;
  bit    lat_chk  = 1'b0;
  beat_t sb_q[$];

  ldl_dff_pipe_v2 #(.WIDTH(8), .LEVEL(3), .RST_DATA(1'b1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  ldl_dff_pipe_v2 #(.WIDTH(8), .LEVEL(0), .RST_DATA(1'b1)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .count(count0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample the handshake at the falling edge, update the
  // scoreboard, then advance past the rising edge.
  task automatic step();
    beat_t b;
    @(negedge clk);
    if (sb_on) begin
      check("count_vs_sb", 32'(count), 32'(sb_q.size()));
      if (out_valid && out_ready) begin
        check("sb_has_beat", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          b = sb_q.pop_front();
          check("out_data", 32'(out_data), 32'(b.data));
          if (lat_chk) check("latency", 32'(cyc - b.cyc), 32'd3);
        end
      end
      if (in_valid && in_ready) begin
        b.data = in_data;
        b.cyc  = cyc;
        sb_q.push_back(b);
      end
      if (flush || rst) sb_q.delete();
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    rst0 = 1'b0; en0 = 1'b1; flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = 8'h00; out_ready0 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    sb_on = 1'b1;

    // Back-to-back stream with the sink always ready.
    out_ready = 1'b1;
    lat_chk   = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      if (i == 4) begin
        check("stream_count", 32'(count), 32'd3);
        check("stream_first_valid", 32'(out_valid), 32'd1);
        check("stream_first_data", 32'(out_data), 32'h01);
      end
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    check("stream_drained", 32'(sb_q.size()), 32'd0);
    check("stream_idle_valid", 32'(out_valid), 32'd0);
    lat_chk = 1'b0;

    // Backpressure: fill to capacity, then pop and push in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      #1;
      if (i < 3) begin
        check("bp_accept", 32'(in_ready), 32'd1);
        step();
      end else begin
        check("bp_full_in_ready", 32'(in_ready), 32'd0);
        check("bp_full_count", 32'(count), 32'd3);
      end
    end
    out_ready = 1'b1;
    #1;
    check("bp_pop_push_ready", 32'(in_ready), 32'd1);
    check("bp_head_data", 32'(out_data), 32'hA0);
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("bp_drained", 32'(sb_q.size()), 32'd0);

    // Bubble collapse under stall.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    in_valid = 1'b1;
    in_data  = 8'h22;
    #1;
    check("bubble_accept", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    step();
    check("bubble_count", 32'(count), 32'd2);
    check("bubble_head_valid", 32'(out_valid), 32'd1);
    check("bubble_head_data", 32'(out_data), 32'h11);
    in_valid = 1'b1;
    in_data  = 8'h33;
    #1;
    check("bubble_one_more", 32'(in_ready), 32'd1);
    step();
    in_data = 8'h44;
    #1;
    check("bubble_full", 32'(in_ready), 32'd0);

    // Flush while full with a beat offered.
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (4) step();

    // Reset mid-stream, then the first beat afterwards sees full latency.
    lat_chk  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h61;
    step();
    in_data = 8'h62;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'h00);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    check("mid_rst_drained", 32'(sb_q.size()), 32'd0);
    lat_chk = 1'b0;

    // Global enable low freezes the pipeline.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    en        = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h56;
    #1;
    check("en0_in_ready", 32'(in_ready), 32'd0);
    check("en0_out_valid", 32'(out_valid), 32'd0);
    repeat (2) step();
    check("en0_count_hold", 32'(count), 32'd1);
    en       = 1'b1;
    in_valid = 1'b0;
    #1;
    check("en1_out_valid", 32'(out_valid), 32'd1);
    check("en1_out_data", 32'(out_data), 32'h55);
    repeat (2) step();
    check("en_drained", 32'(sb_q.size()), 32'd0);

    // LEVEL = 0 pass-through.
    in_valid0 = 1'b1;
    in_data0  = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      out_ready0 = i[0];
      #1;
      check("l0_out_data", 32'(out_data0), 32'h5A);
      check("l0_in_ready", 32'(in_ready0), 32'(i[0]));
      check("l0_out_valid", 32'(out_valid0), 32'd1);
      check("l0_count", 32'(count0), 32'd0);
      @(posedge clk);
    end
    en0        = 1'b0;
    out_ready0 = 1'b1;
    #1;
    check("l0_en0_in_ready", 32'(in_ready0), 32'd0);
    check("l0_en0_out_valid", 32'(out_valid0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
